// File: rtl/or_gate_sweep_ctrl_pkg.sv
// Shared state encoding and default sizing for the or_gate sweep controller.
package or_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DWELL,
      REPORT,
      DONE
   } sweep_state_t;

   localparam int unsigned A_W_DEFAULT   = 4;
   localparam int unsigned EN_W_DEFAULT  = 3;
   localparam int unsigned STEPS_DEFAULT = 4;
   localparam int unsigned DWELL_DEFAULT = 5;

endpackage

// File: rtl/or_gate_sweep_ctrl_if.sv
// Result port of the sweep controller: one sampled b value per step, valid/ready.
interface or_gate_sweep_ctrl_if
   import or_gate_ctrl_pkg::*;
#(
   parameter int unsigned A_W   = A_W_DEFAULT,
   parameter int unsigned IDX_W = $clog2(STEPS_DEFAULT) + 1
);

   logic             res_valid;
   logic             res_ready;
   logic [IDX_W-1:0] res_idx;
   logic [A_W-1:0]   res_data;

   modport master (
      output res_valid,
      output res_idx,
      output res_data,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_idx,
      input  res_data,
      output res_ready
   );

endinterface

// File: rtl/or_gate_sweep_ctrl_dwell_timer.sv
// Loadable down-counter that parks at zero; zero flag marks the end of a dwell.
module or_gate_dwell_timer #(
   parameter int unsigned CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] value,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/or_gate_sweep_ctrl.sv
// Restartable sequencer that steps or_gate through a latched enable mask and reports b per step.
module or_gate_sweep_ctrl
   import or_gate_ctrl_pkg::*;
#(
   parameter int unsigned A_W   = A_W_DEFAULT,
   parameter int unsigned EN_W  = EN_W_DEFAULT,
   parameter int unsigned STEPS = STEPS_DEFAULT,
   parameter int unsigned DWELL = DWELL_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [STEPS-1:0]            pattern,
   output logic [A_W-1:0]              a_out,
   output logic [EN_W-1:0]             en_out,
   input  logic [A_W-1:0]              b_in,
   or_gate_sweep_ctrl_if.master        res,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned IDX_W = $clog2(STEPS) + 1;
   localparam int unsigned CW    = $clog2(DWELL + 1);

   sweep_state_t     state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] nxt;
   logic [STEPS-1:0] pattern_q;
   logic [STEPS-1:0] pat_shift;
   logic             nxt_en;
   logic             last;
   logic             load;
   logic             zero;

   always_comb begin
      nxt       = idx + IDX_W'(1);
      pat_shift = pattern_q >> nxt;
      nxt_en    = pat_shift[0];
      last      = (idx == IDX_W'(STEPS - 1));
      // Timer reloads on the same edges the FSM enters DWELL.
      load      = !abort &&
                  (((state == or_gate_ctrl_pkg::IDLE) && start) ||
                   ((state == or_gate_ctrl_pkg::REPORT) && res.res_ready && !last));
   end

   or_gate_dwell_timer #(
      .CW (CW)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .value (CW'(DWELL - 1)),
      .zero  (zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= or_gate_ctrl_pkg::IDLE;
         idx           <= '0;
         pattern_q     <= '0;
         a_out         <= '0;
         en_out        <= '0;
         res.res_valid <= 1'b0;
         res.res_idx   <= '0;
         res.res_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && (state != or_gate_ctrl_pkg::IDLE)) begin
            state         <= or_gate_ctrl_pkg::IDLE;
            idx           <= '0;
            a_out         <= '0;
            en_out        <= '0;
            res.res_valid <= 1'b0;
            res.res_idx   <= '0;
            res.res_data  <= '0;
            busy          <= 1'b0;
         end else begin
            case (state)
               or_gate_ctrl_pkg::IDLE: begin
                  if (start && !abort) begin
                     pattern_q <= pattern;
                     idx       <= '0;
                     a_out     <= '0;
                     en_out    <= {EN_W{pattern[0]}};
                     busy      <= 1'b1;
                     state     <= or_gate_ctrl_pkg::DWELL;
                  end
               end
               or_gate_ctrl_pkg::DWELL: begin
                  if (zero) begin
                     res.res_data  <= b_in;
                     res.res_idx   <= idx;
                     res.res_valid <= 1'b1;
                     state         <= or_gate_ctrl_pkg::REPORT;
                  end
               end
               or_gate_ctrl_pkg::REPORT: begin
                  if (res.res_ready) begin
                     res.res_valid <= 1'b0;
                     if (last) begin
                        // done and idle operands are registered on entry so DONE shows them.
                        done   <= 1'b1;
                        a_out  <= '0;
                        en_out <= '0;
                        busy   <= 1'b0;
                        state  <= or_gate_ctrl_pkg::DONE;
                     end else begin
                        idx    <= nxt;
                        a_out  <= A_W'(nxt);
                        en_out <= {EN_W{nxt_en}};
                        state  <= or_gate_ctrl_pkg::DWELL;
                     end
                  end
               end
               or_gate_ctrl_pkg::DONE: begin
                  state <= or_gate_ctrl_pkg::IDLE;
               end
               default: state <= or_gate_ctrl_pkg::IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_or_gate_sweep_ctrl.sv
// Directed bench for or_gate_sweep_ctrl with a simple gated-OR load model on b_in.
module tb_or_gate_sweep_ctrl;

   localparam int unsigned A_W   = 4;
   localparam int unsigned EN_W  = 3;
   localparam int unsigned STEPS = 4;
   localparam int unsigned DWELL = 5;
   localparam int unsigned IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [STEPS-1:0] pattern = '0;
   logic [A_W-1:0]   a_out;
   logic [EN_W-1:0]  en_out;
   logic [A_W-1:0]   b_in;
   logic             busy;
   logic             done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   or_gate_sweep_ctrl_if #(.A_W(A_W), .IDX_W(IDX_W)) res_if ();

   // Load stand-in: enabled gate forces the MSB high, disabled gate outputs zero.
   assign b_in = en_out[0] ? (a_out | 4'b1000) : 4'b0000;

   or_gate_sweep_ctrl #(
      .A_W   (A_W),
      .EN_W  (EN_W),
      .STEPS (STEPS),
      .DWELL (DWELL)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .pattern (pattern),
      .a_out   (a_out),
      .en_out  (en_out),
      .b_in    (b_in),
      .res     (res_if),
      .busy    (busy),
      .done    (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_sweep(input logic [3:0] pat, input int stall_step, input int stall_cyc,
                            input int abort_step, input int poke_step);
      logic [2:0] en_e;
      logic [3:0] a_e;
      logic [3:0] b_e;
      pattern = pat;
      res_if.res_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_at_start", busy, 1);
      for (int s = 0; s < STEPS; s++) begin
         en_e = pat[s] ? 3'b111 : 3'b000;
         a_e  = 4'(s);
         b_e  = en_e[0] ? (a_e | 4'b1000) : 4'b0000;
         for (int k = 0; k < DWELL; k++) begin
            check("a_dwell", a_out, a_e);
            check("en_dwell", en_out, en_e);
            check("valid_dwell", res_if.res_valid, 0);
            check("busy_dwell", busy, 1);
            start = 1'b0;
            if (s == poke_step && k == 1) begin
               start   = 1'b1;
               pattern = 4'b0000;
            end
            if (s == abort_step && k == 2) begin
               abort = 1'b1;
               tick();
               abort = 1'b0;
               check("abort_busy", busy, 0);
               check("abort_a", a_out, 0);
               check("abort_en", en_out, 0);
               check("abort_valid", res_if.res_valid, 0);
               check("abort_done", done, 0);
               for (int j = 0; j < 12; j++) begin
                  tick();
                  check("abort_no_done", done, 0);
                  check("abort_idle_busy", busy, 0);
               end
               return;
            end
            tick();
         end
         start = 1'b0;
         check("rep_valid", res_if.res_valid, 1);
         check("rep_idx", res_if.res_idx, s);
         check("rep_data", res_if.res_data, b_e);
         check("rep_a", a_out, a_e);
         check("rep_en", en_out, en_e);
         check("rep_no_done", done, 0);
         if (s == stall_step) begin
            res_if.res_ready = 1'b0;
            for (int j = 0; j < stall_cyc; j++) begin
               tick();
               check("stall_valid", res_if.res_valid, 1);
               check("stall_idx", res_if.res_idx, s);
               check("stall_data", res_if.res_data, b_e);
               check("stall_a", a_out, a_e);
            end
            res_if.res_ready = 1'b1;
         end
         tick();
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_a", a_out, 0);
      check("done_en", en_out, 0);
      check("done_valid", res_if.res_valid, 0);
      tick();
      check("done_cleared", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      res_if.res_ready = 1'b0;
      #12;
      check("rst_a", a_out, 0);
      check("rst_en", en_out, 0);
      check("rst_valid", res_if.res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick();

      // full sweep, all steps enabled
      run_sweep(4'b1111, -1, 0, -1, -1);
      // alternating enables
      run_sweep(4'b0101, -1, 0, -1, -1);
      // consumer stall on step 1
      run_sweep(4'b1111, 1, 3, -1, -1);
      // abort at cnt==2 of step 2
      run_sweep(4'b1111, -1, 0, 2, -1);

      // asynchronous reset while a result is pending
      pattern = 4'b1111;
      res_if.res_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (DWELL) tick();
      check("pre_rst_valid", res_if.res_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_a", a_out, 0);
      check("arst_en", en_out, 0);
      check("arst_valid", res_if.res_valid, 0);
      check("arst_idx", res_if.res_idx, 0);
      check("arst_data", res_if.res_data, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      #3 rst_n = 1'b1;
      tick();
      run_sweep(4'b1111, -1, 0, -1, -1);

      // start re-pulsed mid-sweep with a new mask must be ignored
      run_sweep(4'b1011, -1, 0, -1, 0);

      // start and abort together in IDLE
      pattern = 4'b1111;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", busy, 0);
      check("sa_a", a_out, 0);
      check("sa_en", en_out, 0);
      repeat (DWELL + 1) tick();
      check("sa_valid", res_if.res_valid, 0);
      check("sa_busy_late", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
